shader_prog_ctrl: RTL
=====================

// Module: shader_prog_ctrl
// PURPOSE
//   Command controller between the SPI byte deserializer and the shader core's instruction store.
//   Decodes SPI command bytes and writes a shadow (load) program bank.
//   Swaps shadow and active banks only on a frame boundary, so the shader never runs a half-loaded program.
//   Serves the core's per-cycle instruction fetch from the active bank.
// PARAMETERS
//   NUM_INSTR   8   instructions per bank (power of 2, 2..32)
//   INSTR_W     8   instruction width in bits (fixed 8: one SPI byte per instruction)
// PORTS
//   clk_i          in   1        system clock
//   rst_ni         in   1        synchronous active-low reset
//   spi_cs_i       in   1        SPI chip select, active low; high = abort/idle
//   rx_valid_i     in   1        1-cycle pulse: rx_data_i holds a complete received byte
//   rx_data_i      in   8        received SPI byte
//   tx_data_o      out  8        byte for the SPI shifter to return on MISO
//   tx_load_o      out  1        1-cycle pulse: shifter latches tx_data_o
//   frame_start_i  in   1        1-cycle pulse at start of frame (next_frame from timing)
//   fetch_addr_i   in   $clog2(NUM_INSTR)  core fetch address into the active bank
//   fetch_instr_o  out  INSTR_W  active-bank instruction, registered (1-cycle latency)
//   swap_pending_o out  1        SWAP requested, not yet taken
//   busy_o         out  1        command parser not in IDLE
// BEHAVIOUR
//   Reset (rst_ni=0 at a clk_i edge)
//     - both banks cleared to 8'h00; active bank = bank0; state = IDLE
//     - tx_data_o=0, tx_load_o=0, fetch_instr_o=0, swap_pending_o=0, busy_o=0
//     - reset mid-command discards the command; mid-burst writes already made are lost (banks cleared)
//   Command opcode, first byte after CS falls:
//     - 8'h00 NOP: no effect
//     - 8'h01 WRITE: next byte addr, next byte data -> shadow[addr % NUM_INSTR]
//     - 8'h02 BURST: next NUM_INSTR bytes -> shadow[0..NUM_INSTR-1] in order
//     - 8'h03 READ: next byte addr -> response shadow[addr % NUM_INSTR]
//     - 8'h04 SWAP: swap_pending_o <= 1
//     - any other opcode: ignored, parser stays in IDLE
//   FSM states: IDLE, ADDR, DATA, BURST, RESP
//     - IDLE -rx 01-> ADDR(wr); IDLE -rx 03-> ADDR(rd); IDLE -rx 02-> BURST, cnt=0
//     - ADDR(wr) -rx-> DATA; DATA -rx-> write shadow, IDLE
//     - ADDR(rd) -rx-> RESP; RESP -> IDLE after one cycle
//     - BURST: each rx writes shadow[cnt], cnt++; write at cnt==NUM_INSTR-1 -> IDLE
//       (counter does not wrap into a second pass)
//     - spi_cs_i==1 in any cycle forces IDLE and cnt=0, with priority over rx_valid_i;
//       completed writes stay in the shadow bank
//   READ response
//     - in RESP: tx_data_o <= shadow[addr], tx_load_o=1 for exactly 1 cycle
//     - response is loaded 2 cycles after the address byte's rx_valid_i
//     - tx_data_o holds its value until the next load
//   Shadow writes take effect the cycle after the data byte's rx_valid_i
//   Swap
//     - on frame_start_i with swap_pending_o=1: active bank toggles, swap_pending_o <= 0
//     - SWAP and frame_start_i in the same cycle: pending sets, swap waits for the next frame_start_i
//     - after a swap, the new shadow bank is a copy of the new active bank, so incremental
//       WRITEs edit the current program (copy done in that same cycle, all entries)
//     - a shadow write in the swap cycle lands in the copied shadow bank; the copy must not overwrite it
//   Fetch
//     - fetch_instr_o <= active[fetch_addr_i] every cycle, regardless of parser state
//     - new active program visible on fetch_instr_o the cycle after the swap edge
//   busy_o = (state != IDLE)
// TESTING
//   1. Reset, then fetch all addresses -> fetch_instr_o = 00 everywhere; all outputs 0
//   2. CS low; 01,03,A5 -> shadow[3]=A5, active unchanged
//      -> frame_start without SWAP: fetch addr 3 still 00
//   3. BURST 02,10..17; SWAP 04; frame_start
//      -> fetch[i] = 10+i next cycle; swap_pending_o 1 -> 0
//   4. After test 3: READ 03,05 -> tx_load_o pulse 2 cycles after the addr byte, tx_data_o = 15
//      -> READ addr 0D (mod 8 = 5) -> 15
//   5. BURST 02 + 3 bytes, then CS high -> IDLE, busy_o=0
//      -> shadow[0..2] new, shadow[3..7] unchanged; next byte 01 parsed as opcode
//   6. SWAP byte coincident with frame_start -> no swap that frame; swap on the following frame_start

Source files
------------

// File: rtl/shader_prog_ctrl.sv
// Command controller between the SPI byte deserializer and the shader instruction store.
// Decodes SPI commands into a shadow program bank; swaps to active only on frame boundaries.
module shader_prog_ctrl #(
  parameter int NUM_INSTR = 8,
  parameter int INSTR_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         spi_cs_i,
  input  logic                         rx_valid_i,
  input  logic [7:0]                   rx_data_i,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_load_o,
  input  logic                         frame_start_i,
  input  logic [$clog2(NUM_INSTR)-1:0] fetch_addr_i,
  output logic [INSTR_W-1:0]           fetch_instr_o,
  output logic                         swap_pending_o,
  output logic                         busy_o
);

  localparam int AW = $clog2(NUM_INSTR);
  localparam logic [AW-1:0] LAST = AW'(NUM_INSTR - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BURST, RESP} state_t;

  state_t             state;
  logic [INSTR_W-1:0] bank [2][NUM_INSTR];
  logic               active_sel;
  logic               rd_mode;
  logic [AW-1:0]      addr_q;
  logic [AW-1:0]      cnt;

  logic               rx_ok;
  logic               swap_now;
  logic               set_swap;
  logic               shadow_sel;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;

  // In the swap cycle the old active bank becomes the shadow, so writes must target it.
  always_comb begin
    rx_ok      = rx_valid_i && !spi_cs_i;
    swap_now   = frame_start_i && swap_pending_o;
    set_swap   = rx_ok && (state == IDLE) && (rx_data_i == 8'h04);
    shadow_sel = swap_now ? active_sel : ~active_sel;
    wr_en      = 1'b0;
    wr_addr    = addr_q;
    if (rx_ok && state == DATA) begin
      wr_en = 1'b1;
    end else if (rx_ok && state == BURST) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
    end
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      active_sel     <= 1'b0;
      rd_mode        <= 1'b0;
      addr_q         <= '0;
      cnt            <= '0;
      tx_data_o      <= '0;
      tx_load_o      <= 1'b0;
      fetch_instr_o  <= '0;
      swap_pending_o <= 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) begin
        bank[0][i] <= '0;
        bank[1][i] <= '0;
      end
    end else begin
      fetch_instr_o <= bank[active_sel][fetch_addr_i];
      tx_load_o     <= 1'b0;

      // Refresh the outgoing active bank with the new program; a same-cycle write below wins.
      if (swap_now) begin
        active_sel <= ~active_sel;
        for (int i = 0; i < NUM_INSTR; i++) begin
          bank[active_sel][i] <= bank[~active_sel][i];
        end
      end

      if (wr_en) begin
        bank[shadow_sel][wr_addr] <= rx_data_i[INSTR_W-1:0];
      end

      if (set_swap) begin
        swap_pending_o <= 1'b1;
      end else if (swap_now) begin
        swap_pending_o <= 1'b0;
      end

      if (spi_cs_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid_i) begin
              case (rx_data_i)
                8'h01: begin
                  state   <= ADDR;
                  rd_mode <= 1'b0;
                end
                8'h02: begin
                  state <= BURST;
                  cnt   <= '0;
                end
                8'h03: begin
                  state   <= ADDR;
                  rd_mode <= 1'b1;
                end
                default: state <= IDLE;
              endcase
            end
          end
          ADDR: begin
            if (rx_valid_i) begin
              addr_q <= rx_data_i[AW-1:0];
              state  <= rd_mode ? RESP : DATA;
            end
          end
          DATA: begin
            if (rx_valid_i) begin
              state <= IDLE;
            end
          end
          BURST: begin
            if (rx_valid_i) begin
              if (cnt == LAST) begin
                state <= IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          RESP: begin
            tx_data_o <= bank[~active_sel][addr_q];
            tx_load_o <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
